// File: rtl/reg_native_if_arbiter.sv
// Round-robin arbiter merging REQ_NUM native register requesters onto one downstream port.
// Each requester has one pending slot, and only one downstream transaction is outstanding at a time.
module reg_native_if_arbiter #(
  parameter int unsigned REQ_NUM        = 2,
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned BUS_ADDR_WIDTH = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] TIMEOUT_RD_DATA = BUS_DATA_WIDTH'(32'hdead_beef)
) (
  input  logic                               native_clk,
  input  logic                               native_rst_n,
  input  logic [REQ_NUM-1:0]                 s_req_vld,
  input  logic [REQ_NUM*BUS_ADDR_WIDTH-1:0]  s_addr,
  input  logic [REQ_NUM-1:0]                 s_wr_en,
  input  logic [REQ_NUM-1:0]                 s_rd_en,
  input  logic [REQ_NUM*BUS_DATA_WIDTH-1:0]  s_wr_data,
  output logic [REQ_NUM-1:0]                 s_ack_vld,
  output logic [BUS_DATA_WIDTH-1:0]          s_rd_data,
  output logic                               m_req_vld,
  output logic [BUS_ADDR_WIDTH-1:0]          m_addr,
  output logic                               m_wr_en,
  output logic                               m_rd_en,
  output logic [BUS_DATA_WIDTH-1:0]          m_wr_data,
  input  logic                               m_ack_vld,
  input  logic [BUS_DATA_WIDTH-1:0]          m_rd_data,
  output logic                               timeout_err,
  output logic                               overflow_err
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                    state;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          grant;
  logic [CNT_W-1:0]          cnt;
  logic [REQ_NUM-1:0]        pending;
  logic [BUS_ADDR_WIDTH-1:0] slot_addr    [REQ_NUM];
  logic [BUS_DATA_WIDTH-1:0] slot_wr_data [REQ_NUM];
  logic [REQ_NUM-1:0]        slot_wr_en;
  logic [REQ_NUM-1:0]        slot_rd_en;

  logic                      limit_c;
  logic                      done_c;
  logic                      timeout_c;
  logic [REQ_NUM-1:0]        clr_c;
  logic [REQ_NUM-1:0]        ovf_c;
  logic                      found_c;
  logic [PTR_W-1:0]          sel_c;

  // Completion this cycle: real ack, or forced ack when the wait budget is spent
  always_comb begin
    limit_c   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    done_c    = (state == ST_WAIT) && (m_ack_vld || limit_c);
    timeout_c = (state == ST_WAIT) && !m_ack_vld && limit_c;
    clr_c     = '0;
    ovf_c     = '0;
    for (int i = 0; i < int'(REQ_NUM); i++) begin
      clr_c[i] = done_c && (grant == PTR_W'(i));
      ovf_c[i] = s_req_vld[i] && pending[i] && !clr_c[i];
    end
  end

  // First pending requester at or after rr_ptr, wrapping
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    sel_c   = '0;
    idx     = 0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found_c && pending[PTR_W'(idx)]) begin
        found_c = 1'b1;
        sel_c   = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge native_clk) begin
    if (!native_rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      cnt          <= '0;
      pending      <= '0;
      slot_wr_en   <= '0;
      slot_rd_en   <= '0;
      for (int i = 0; i < int'(REQ_NUM); i++) begin
        slot_addr[i]    <= '0;
        slot_wr_data[i] <= '0;
      end
      s_ack_vld    <= '0;
      s_rd_data    <= '0;
      m_req_vld    <= 1'b0;
      m_addr       <= '0;
      m_wr_en      <= 1'b0;
      m_rd_en      <= 1'b0;
      m_wr_data    <= '0;
      timeout_err  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      m_req_vld    <= 1'b0;
      s_ack_vld    <= '0;
      timeout_err  <= 1'b0;
      overflow_err <= |ovf_c;

      // Slot load wins over the clear from a completion in the same cycle
      for (int i = 0; i < int'(REQ_NUM); i++) begin
        if (s_req_vld[i] && (!pending[i] || clr_c[i])) begin
          pending[i]      <= 1'b1;
          slot_addr[i]    <= s_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
          slot_wr_data[i] <= s_wr_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
          slot_wr_en[i]   <= s_wr_en[i];
          slot_rd_en[i]   <= s_rd_en[i];
        end else if (clr_c[i]) begin
          pending[i] <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: begin
          if (found_c) begin
            grant     <= sel_c;
            m_req_vld <= 1'b1;
            m_addr    <= slot_addr[sel_c];
            m_wr_en   <= slot_wr_en[sel_c];
            m_rd_en   <= slot_rd_en[sel_c];
            m_wr_data <= slot_wr_data[sel_c];
            cnt       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (done_c) begin
            s_rd_data        <= m_ack_vld ? m_rd_data : TIMEOUT_RD_DATA;
            s_ack_vld[grant] <= 1'b1;
            timeout_err      <= timeout_c;
            rr_ptr           <= (int'(grant) == int'(REQ_NUM) - 1) ? '0 : grant + PTR_W'(1);
            cnt              <= '0;
            state            <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_if_arbiter.sv
// Directed bench for reg_native_if_arbiter: two requesters, 4-cycle timeout.
module tb_reg_native_if_arbiter;

  localparam int unsigned RN = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 64;

  logic              native_clk = 1'b0;
  logic              native_rst_n;
  logic [RN-1:0]     s_req_vld;
  logic [RN*AW-1:0]  s_addr;
  logic [RN-1:0]     s_wr_en;
  logic [RN-1:0]     s_rd_en;
  logic [RN*DW-1:0]  s_wr_data;
  logic [RN-1:0]     s_ack_vld;
  logic [DW-1:0]     s_rd_data;
  logic              m_req_vld;
  logic [AW-1:0]     m_addr;
  logic              m_wr_en;
  logic              m_rd_en;
  logic [DW-1:0]     m_wr_data;
  logic              m_ack_vld;
  logic [DW-1:0]     m_rd_data;
  logic              timeout_err;
  logic              overflow_err;

  int n_chk  = 0;
  int n_pass = 0;

  reg_native_if_arbiter #(
    .REQ_NUM(RN), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(4), .TIMEOUT_RD_DATA(32'hdead_beef)
  ) dut (
    .native_clk(native_clk), .native_rst_n(native_rst_n),
    .s_req_vld(s_req_vld), .s_addr(s_addr), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_wr_data(s_wr_data), .s_ack_vld(s_ack_vld), .s_rd_data(s_rd_data),
    .m_req_vld(m_req_vld), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_wr_data(m_wr_data), .m_ack_vld(m_ack_vld), .m_rd_data(m_rd_data),
    .timeout_err(timeout_err), .overflow_err(overflow_err)
  );

  always #5 native_clk = ~native_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge native_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req_vld[i]           = 1'b1;
    s_wr_en[i]             = wr;
    s_rd_en[i]             = rd;
    s_addr[i*AW +: AW]     = a;
    s_wr_data[i*DW +: DW]  = d;
  endtask

  task automatic do_reset();
    native_rst_n = 1'b0;
    s_req_vld = '0; s_addr = '0; s_wr_en = '0; s_rd_en = '0; s_wr_data = '0;
    m_ack_vld = 1'b0; m_rd_data = '0;
    step(); step();
    native_rst_n = 1'b1;
  endtask

  // Wait for the next downstream request, check it, ack one cycle later
  task automatic serve(input string tag, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int t = 0; t < 20 && !m_req_vld; t++) step();
    check({tag, "_req"}, 64'(m_req_vld), 64'(1));
    check({tag, "_addr"}, m_addr, a);
    step();
    m_ack_vld = 1'b1;
    m_rd_data = d;
    step();
    m_ack_vld = 1'b0;
    check({tag, "_ack"}, 64'(s_ack_vld), 64'(1 << idx));
    check({tag, "_rdata"}, 64'(s_rd_data), 64'(d));
  endtask

  initial begin
    int cnt;
    // Reset state
    do_reset();
    check("rst_m_req", 64'(m_req_vld), 64'(0));
    check("rst_s_ack", 64'(s_ack_vld), 64'(0));
    check("rst_m_addr", m_addr, 64'(0));
    check("rst_rdata", 64'(s_rd_data), 64'(0));
    check("rst_errs", 64'({timeout_err, overflow_err}), 64'(0));

    // Single read; ack lands on the timeout cycle, real ack wins
    set_req(0, 1'b0, 1'b1, 64'h0000_0000_0000_1000, 32'h0);
    step();
    s_req_vld = '0;
    check("rd_c1_noreq", 64'(m_req_vld), 64'(0));
    step();
    check("rd_c2_req", 64'(m_req_vld), 64'(1));
    check("rd_c2_addr", m_addr, 64'h1000);
    check("rd_c2_dir", 64'({m_wr_en, m_rd_en}), 64'(1));
    step();
    check("rd_c3_pulse", 64'(m_req_vld), 64'(0));
    step();
    check("rd_c4_hold", m_addr, 64'h1000);
    step();
    m_ack_vld = 1'b1;
    m_rd_data = 32'h1234_5678;
    step();
    m_ack_vld = 1'b0;
    check("rd_c6_ack", 64'(s_ack_vld), 64'(1));
    check("rd_c6_rdata", 64'(s_rd_data), 64'h1234_5678);
    check("rd_c6_noto", 64'(timeout_err), 64'(0));
    step();
    check("rd_c7_ackoff", 64'(s_ack_vld), 64'(0));

    // Timeout: downstream never acks
    do_reset();
    set_req(0, 1'b0, 1'b1, 64'h2000, 32'h0);
    step(); s_req_vld = '0;
    step();
    check("to_c2_req", 64'(m_req_vld), 64'(1));
    step(); step(); step();
    check("to_c5_noack", 64'(s_ack_vld), 64'(0));
    step();
    check("to_c6_ack", 64'(s_ack_vld), 64'(1));
    check("to_c6_rdata", 64'(s_rd_data), 64'hdead_beef);
    check("to_c6_err", 64'(timeout_err), 64'(1));
    m_ack_vld = 1'b1;
    m_rd_data = 32'h5555_5555;
    step();
    m_ack_vld = 1'b0;
    check("to_c7_err", 64'(timeout_err), 64'(0));
    step();
    check("to_late_ack", 64'(s_ack_vld), 64'(0));
    check("to_late_rdata", 64'(s_rd_data), 64'hdead_beef);

    // Two requesters together, four rounds: grants alternate 0,1
    do_reset();
    for (int r = 0; r < 4; r++) begin
      set_req(0, 1'b0, 1'b1, 64'(16'h0100 + r), 32'h0);
      set_req(1, 1'b1, 1'b0, 64'(16'h0200 + r), 32'h0);
      step();
      s_req_vld = '0;
      serve($sformatf("rr%0d_g0", r), 0, 64'(16'h0100 + r), 32'(32'ha000_0000 + r));
      serve($sformatf("rr%0d_g1", r), 1, 64'(16'h0200 + r), 32'(32'hb000_0000 + r));
    end

    // Overflow: requester 1 pulses twice while pending
    do_reset();
    set_req(1, 1'b1, 1'b0, 64'h3000, 32'hcafe_0001);
    step();
    set_req(1, 1'b0, 1'b1, 64'h3333, 32'hcafe_0002);
    step();
    s_req_vld = '0;
    check("ovf_c2_err", 64'(overflow_err), 64'(1));
    check("ovf_c2_req", 64'(m_req_vld), 64'(1));
    check("ovf_c2_addr", m_addr, 64'h3000);
    check("ovf_c2_wdata", 64'(m_wr_data), 64'hcafe_0001);
    check("ovf_c2_dir", 64'({m_wr_en, m_rd_en}), 64'(2));
    step();
    check("ovf_c3_err", 64'(overflow_err), 64'(0));
    set_req(1, 1'b0, 1'b1, 64'h4444, 32'h0);
    step();
    s_req_vld = '0;
    check("ovf_c4_err", 64'(overflow_err), 64'(1));
    check("ovf_c4_hold", m_addr, 64'h3000);
    m_ack_vld = 1'b1;
    m_rd_data = 32'h0;
    step();
    m_ack_vld = 1'b0;
    check("ovf_c5_ack", 64'(s_ack_vld), 64'(2));
    cnt = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (m_req_vld || (s_ack_vld != '0)) cnt++;
    end
    check("ovf_no_extra", 64'(cnt), 64'(0));

    // Reset during WAIT abandons the transaction
    do_reset();
    set_req(0, 1'b0, 1'b1, 64'h5000, 32'h0);
    step(); s_req_vld = '0;
    step();
    check("rw_c2_req", 64'(m_req_vld), 64'(1));
    step();
    native_rst_n = 1'b0;
    step();
    native_rst_n = 1'b1;
    m_ack_vld = 1'b1;
    m_rd_data = 32'h7777_7777;
    check("rw_outs_zero", 64'({s_ack_vld, m_req_vld, m_wr_en, m_rd_en, timeout_err, overflow_err}), 64'(0));
    check("rw_addr_zero", m_addr, 64'(0));
    check("rw_data_zero", 64'({s_rd_data, m_wr_data}), 64'(0));
    step();
    m_ack_vld = 1'b0;
    check("rw_no_ack", 64'(s_ack_vld), 64'(0));
    set_req(0, 1'b0, 1'b1, 64'h6000, 32'h0);
    set_req(1, 1'b0, 1'b1, 64'h6100, 32'h0);
    step(); s_req_vld = '0;
    serve("rw_g0", 0, 64'h6000, 32'h0000_6000);
    serve("rw_g1", 1, 64'h6100, 32'h0000_6100);

    // Re-request in ack cycle is accepted and served after requester 1
    do_reset();
    set_req(0, 1'b0, 1'b1, 64'h7000, 32'h0);
    set_req(1, 1'b0, 1'b1, 64'h7100, 32'h0);
    step(); s_req_vld = '0;
    step();
    check("rq_c2_addr", m_addr, 64'h7000);
    step();
    m_ack_vld = 1'b1;
    m_rd_data = 32'h0000_7000;
    set_req(0, 1'b1, 1'b0, 64'h7200, 32'h0);
    step();
    m_ack_vld = 1'b0;
    s_req_vld = '0;
    check("rq_c4_ack", 64'(s_ack_vld), 64'(1));
    check("rq_c4_noovf", 64'(overflow_err), 64'(0));
    serve("rq_g1", 1, 64'h7100, 32'h0000_7100);
    serve("rq_g0", 0, 64'h7200, 32'h0000_7200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_native_if_arbiter.md
REG_NATIVE_IF_ARBITER -- requirements
Module: reg_native_if_arbiter

Interface
REQ-001 Parameters SHALL be: REQ_NUM, default 2, number of upstream requesters (2..8); BUS_DATA_WIDTH, default 32, data width; BUS_ADDR_WIDTH, default 64, address width; TIMEOUT_CYCLES, default 255, WAIT cycles before forced ack (1..65535); TIMEOUT_RD_DATA, default 32'hdead_beef, rd data returned on timeout.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
native_clk  in  1  sole clock
native_rst_n  in  1  synchronous active-low reset
s_req_vld  in  REQ_NUM  per-requester one-cycle request pulse
s_addr  in  REQ_NUM*BUS_ADDR_WIDTH  request address, slice i = requester i
s_wr_en  in  REQ_NUM  write request
s_rd_en  in  REQ_NUM  read request
s_wr_data  in  REQ_NUM*BUS_DATA_WIDTH  write data, slice i
s_ack_vld  out  REQ_NUM  per-requester one-cycle ack pulse
s_rd_data  out  BUS_DATA_WIDTH  shared read data, qualified by s_ack_vld[i]
m_req_vld  out  1  downstream request pulse
m_addr  out  BUS_ADDR_WIDTH  downstream address
m_wr_en  out  1  downstream write
m_rd_en  out  1  downstream read
m_wr_data  out  BUS_DATA_WIDTH  downstream write data
m_ack_vld  in  1  downstream ack pulse
m_rd_data  in  BUS_DATA_WIDTH  downstream read data, valid with m_ack_vld
timeout_err  out  1  one-cycle pulse on forced ack
overflow_err  out  1  one-cycle pulse when a request is dropped

Function
REQ-004 Block SHALL hold one pending slot per requester (addr, wr_en, rd_en, wr_data, pending flag); s_req_vld[i] with pending[i]=0 loads slot i; pending[i] set next cycle.
REQ-005 s_req_vld[i] while pending[i]=1 and not being cleared that cycle SHALL be dropped, slot unchanged, overflow_err pulsed next cycle.
REQ-006 s_req_vld[i] in the same cycle pending[i] clears (ack cycle) SHALL be accepted; set wins over clear.
REQ-007 FSM states SHALL be IDLE and WAIT; exactly one downstream transaction outstanding.
REQ-008 IDLE: if any pending flag set, grant SHALL go to the first pending index at or after rr_ptr, wrapping modulo REQ_NUM; m_* loaded from that slot, m_req_vld high one cycle, move to WAIT.
REQ-009 m_addr/m_wr_en/m_rd_en/m_wr_data SHALL be registered and held stable from m_req_vld until return to IDLE.
REQ-010 WAIT: on m_ack_vld, s_rd_data <= m_rd_data, s_ack_vld[grant] pulses one cycle, pending[grant] cleared, rr_ptr <= (grant+1) mod REQ_NUM, move to IDLE.
REQ-011 WAIT counter SHALL start at 0 on entry and increment each WAIT cycle without ack; at count == TIMEOUT_CYCLES-1 without ack, completion per REQ-010 SHALL occur with s_rd_data <= TIMEOUT_RD_DATA plus timeout_err pulse.
REQ-012 m_ack_vld and timeout in the same cycle: real ack SHALL win, no timeout_err.
REQ-013 m_ack_vld in IDLE (late or spurious) SHALL be ignored.
REQ-014 Latency: s_req_vld at cycle 0 into idle block with no other pending -> m_req_vld at cycle 2; m_ack_vld at cycle k -> s_ack_vld at k+1; next m_req_vld no earlier than k+2.
REQ-015 Requests with both or neither of wr_en/rd_en SHALL be forwarded unchanged.

Reset
REQ-016 While native_rst_n=0 at a clock edge: state IDLE, all pending flags 0, rr_ptr 0, counter 0, all outputs 0 (m_addr, m_wr_data, s_rd_data included).
REQ-017 Reset in WAIT SHALL abandon the transaction without any s_ack_vld; ack arriving after reset ignored per REQ-013.

Verification
REQ-018 Single read from requester 0, downstream ack after 3 cycles with m_rd_data=32'h1234_5678 -> m_req_vld at cycle 2, s_ack_vld[0] one cycle, s_rd_data=32'h1234_5678.
REQ-019 Requesters 0 and 1 pulse same cycle, repeated 4 times -> grants alternate 0,1,0,1,...; each requester acked in its own cycle, none lost.
REQ-020 Downstream never acks, TIMEOUT_CYCLES=4 -> s_ack_vld at 4th WAIT cycle +1, s_rd_data=32'hdead_beef, timeout_err one pulse; later m_ack_vld ignored.
REQ-021 Requester 1 pulses twice while its first request is pending -> second dropped, overflow_err pulse, exactly one ack to requester 1.
REQ-022 native_rst_n low 1 cycle during WAIT, then ack -> no s_ack_vld, all outputs 0 after reset, next request served normally with grant from index 0.
REQ-023 Requester 0 re-requests in its ack cycle -> accepted, served after any other pending requester.
